// File: rtl/tmr_scrub_mem_if.sv
// Processor-side SRAM client bus for tmr_scrub_mem.
//   master : drives we/re/addr/wdata, receives rdata/rvalid/rerr
//   slave  : the memory side
interface tmr_scrub_mem_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rerr;

    modport master (
        output we, re, addr, wdata,
        input  rdata, rvalid, rerr
    );

    modport slave (
        input  we, re, addr, wdata,
        output rdata, rvalid, rerr
    );
endinterface

// File: rtl/tmr_scrub_mem.sv
// Triplicated single-port memory with majority-voted reads, scrub-on-read
// repair, deferred repair, a background scrubber, error counters, a sticky
// per-replica fault map and a fault-injection port.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       we/re/addr/wdata in; rdata/rvalid/rerr out
//   inj_en/sel/mask   XOR mask into one replica at bus.addr (sel 3 = no-op)
//   clr_stats         synchronous clear of counters and fault_map
//   corr_cnt          saturating count of corrected words
//   uncorr_cnt        saturating count of uncorrectable words
//   fault_map         sticky: bit k set once replica k was repaired
//   scrub_busy        a scrub read or its repair is in flight
//   scrub_wrap        one-cycle pulse when the scrub address wraps to 0
module tmr_scrub_mem #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned SCRUB_EN       = 1,
    parameter int unsigned SCRUB_INTERVAL = 16,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    tmr_scrub_mem_if.slave    bus,
    input  logic              inj_en,
    input  logic [1:0]        inj_sel,
    input  logic [DATA_W-1:0] inj_mask,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt,
    output logic [2:0]        fault_map,
    output logic              scrub_busy,
    output logic              scrub_wrap
);
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned IDLE_W = $clog2(SCRUB_INTERVAL + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(SCRUB_INTERVAL - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RD, ST_CHK} state_t;

    logic [DATA_W-1:0] mem_q [3][DEPTH];

    // read capture stage
    logic              cap_v_q;
    logic              cap_user_q;
    logic [ADDR_W-1:0] cap_addr_q;
    logic [DATA_W-1:0] cap_w_q [3];

    // one-entry pending repair
    logic              pend_v_q;
    logic              pend_scrub_q;
    logic [ADDR_W-1:0] pend_addr_q;
    logic [DATA_W-1:0] pend_data_q;
    logic [2:0]        pend_mask_q;

    state_t            state_q;
    logic [IDLE_W-1:0] idle_q;
    logic [ADDR_W-1:0] scrub_addr_q;
    logic              scrub_busy_q;
    logic              scrub_wrap_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              rerr_q;
    logic [CNT_W-1:0]  corr_q;
    logic [CNT_W-1:0]  uncorr_q;
    logic [2:0]        fmap_q;

    // classification of the captured word
    logic [DATA_W-1:0] voted;
    logic [2:0]        diff;
    logic              uncorr;
    logic              corr;

    always_comb begin
        voted = (cap_w_q[0] & cap_w_q[1]) | (cap_w_q[1] & cap_w_q[2]) |
                (cap_w_q[0] & cap_w_q[2]);
        diff = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            diff[k] = (cap_w_q[k] != voted);
        end
        uncorr = cap_v_q && (cap_w_q[0] != cap_w_q[1]) &&
                 (cap_w_q[1] != cap_w_q[2]) && (cap_w_q[0] != cap_w_q[2]);
        corr   = cap_v_q && !uncorr && (diff != 3'b000);
    end

    // scrub issue: only when the port, the pending slot and the scrubber are all quiet
    logic port_idle;
    logic scrub_issue;

    always_comb begin
        port_idle   = !bus.re && !bus.we && !inj_en && !pend_v_q &&
                      (state_q == ST_IDLE || state_q == ST_WAIT);
        scrub_issue = (SCRUB_EN != 0) && port_idle && (idle_q == IDLE_LAST);
    end

    // A fresh correction supersedes (drops) any pending one. A blocked
    // candidate is parked unless the blocking write hits its address, in
    // which case the newer data owns the word and the repair is discarded.
    logic              cand_v;
    logic              cand_scrub;
    logic [ADDR_W-1:0] cand_addr;
    logic [DATA_W-1:0] cand_data;
    logic [2:0]        cand_mask;
    logic              wr_block;
    logic              rep_fire;
    logic              pend_v_d;
    logic              pend_scrub_d;
    logic [ADDR_W-1:0] rd_addr;

    always_comb begin
        cand_v       = corr || pend_v_q;
        cand_scrub   = corr ? !cap_user_q : pend_scrub_q;
        cand_addr    = corr ? cap_addr_q  : pend_addr_q;
        cand_data    = corr ? voted       : pend_data_q;
        cand_mask    = corr ? diff        : pend_mask_q;
        wr_block     = bus.we || inj_en;
        rep_fire     = cand_v && !wr_block;
        pend_v_d     = cand_v && wr_block && (bus.addr != cand_addr);
        pend_scrub_d = cand_scrub;
        rd_addr      = bus.re ? bus.addr : scrub_addr_q;
    end

    // memory replicas: write priority we > injection > repair
    always_ff @(posedge clk) begin
        if (bus.we) begin
            for (int unsigned k = 0; k < 3; k++) begin
                mem_q[k][bus.addr] <= bus.wdata;
            end
        end else if (inj_en) begin
            for (int unsigned k = 0; k < 3; k++) begin
                if (inj_sel == 2'(k)) begin
                    mem_q[k][bus.addr] <= mem_q[k][bus.addr] ^ inj_mask;
                end
            end
        end else if (rep_fire) begin
            for (int unsigned k = 0; k < 3; k++) begin
                if (cand_mask[k]) begin
                    mem_q[k][cand_addr] <= cand_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_v_q      <= 1'b0;
            cap_user_q   <= 1'b0;
            cap_addr_q   <= '0;
            for (int unsigned k = 0; k < 3; k++) begin
                cap_w_q[k] <= '0;
            end
            pend_v_q     <= 1'b0;
            pend_scrub_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            pend_mask_q  <= '0;
            state_q      <= ST_IDLE;
            idle_q       <= '0;
            scrub_addr_q <= '0;
            scrub_busy_q <= 1'b0;
            scrub_wrap_q <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            rerr_q       <= 1'b0;
            corr_q       <= '0;
            uncorr_q     <= '0;
            fmap_q       <= '0;
        end else begin
            // capture reads old contents (read-before-write with any write this edge)
            cap_v_q    <= bus.re || scrub_issue;
            cap_user_q <= bus.re;
            if (bus.re || scrub_issue) begin
                cap_addr_q <= rd_addr;
                for (int unsigned k = 0; k < 3; k++) begin
                    cap_w_q[k] <= mem_q[k][rd_addr];
                end
            end

            rvalid_q <= cap_v_q && cap_user_q;
            rerr_q   <= cap_v_q && cap_user_q && uncorr;
            if (cap_v_q && cap_user_q) begin
                rdata_q <= voted;
            end

            pend_v_q <= pend_v_d;
            if (pend_v_d) begin
                pend_scrub_q <= cand_scrub;
                pend_addr_q  <= cand_addr;
                pend_data_q  <= cand_data;
                pend_mask_q  <= cand_mask;
            end

            if (clr_stats) begin
                corr_q   <= '0;
                uncorr_q <= '0;
                fmap_q   <= '0;
            end else begin
                if (corr && corr_q != '1) begin
                    corr_q <= corr_q + 1'b1;
                end
                if (uncorr && uncorr_q != '1) begin
                    uncorr_q <= uncorr_q + 1'b1;
                end
                if (corr) begin
                    fmap_q <= fmap_q | diff;
                end
            end

            case (state_q)
                ST_IDLE, ST_WAIT: begin
                    if (scrub_issue) begin
                        state_q <= ST_RD;
                    end else if (port_idle) begin
                        state_q <= ST_WAIT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RD, ST_CHK: begin
                    state_q <= (pend_v_d && pend_scrub_d) ? ST_CHK : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            scrub_busy_q <= scrub_issue || (pend_v_d && pend_scrub_d);

            if (scrub_issue || !port_idle) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + 1'b1;
            end

            scrub_wrap_q <= scrub_issue && (scrub_addr_q == '1);
            if (scrub_issue) begin
                scrub_addr_q <= scrub_addr_q + 1'b1;
            end
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rerr   = rerr_q;
    assign corr_cnt   = corr_q;
    assign uncorr_cnt = uncorr_q;
    assign fault_map  = fmap_q;
    assign scrub_busy = scrub_busy_q;
    assign scrub_wrap = scrub_wrap_q;
endmodule

// File: tb/tb_tmr_scrub_mem.sv
// Self-checking bench for tmr_scrub_mem: directed scenarios followed by
// randomized traffic, all checked cycle by cycle against a behavioural model.
module tb_tmr_scrub_mem;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned SI    = 4;
    localparam int unsigned CW    = 4;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int          CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          inj_en = 1'b0;
    logic [1:0]    inj_sel = '0;
    logic [DW-1:0] inj_mask = '0;
    logic          clr_stats = 1'b0;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] uncorr_cnt;
    logic [2:0]    fault_map;
    logic          scrub_busy;
    logic          scrub_wrap;

    tmr_scrub_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    tmr_scrub_mem #(
        .ADDR_W(AW), .DATA_W(DW), .SCRUB_EN(1), .SCRUB_INTERVAL(SI), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask),
        .clr_stats(clr_stats),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .fault_map(fault_map),
        .scrub_busy(scrub_busy), .scrub_wrap(scrub_wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wrap   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [3][DEPTH];
    bit            m_cap_v, m_cap_u;
    int            m_cap_a;
    logic [DW-1:0] m_cap_w [3];
    bit            m_pend_v, m_pend_scrub;
    int            m_pend_a;
    logic [DW-1:0] m_pend_d;
    logic [2:0]    m_pend_mask;
    int            m_idle, m_saddr;
    bit            m_busy, m_wrap, m_rvalid, m_rerr;
    logic [DW-1:0] m_rdata;
    int            m_corr, m_uncorr;
    logic [2:0]    m_fmap;

    function automatic logic [DW-1:0] majority(input logic [DW-1:0] a, b, c);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) begin
            int votes;
            votes = int'(a[i]) + int'(b[i]) + int'(c[i]);
            r[i] = (votes >= 2);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_cap_v = 0; m_cap_u = 0; m_cap_a = 0;
        for (int k = 0; k < 3; k++) m_cap_w[k] = '0;
        m_pend_v = 0; m_pend_scrub = 0; m_pend_a = 0; m_pend_d = '0; m_pend_mask = '0;
        m_idle = 0; m_saddr = 0; m_busy = 0; m_wrap = 0;
        m_rvalid = 0; m_rerr = 0; m_rdata = '0;
        m_corr = 0; m_uncorr = 0; m_fmap = '0;
    endtask

    // one clock edge of the specified behaviour, using the inputs as sampled
    task automatic model_step();
        logic [DW-1:0] v;
        logic [2:0]    bad, c_mask;
        logic [DW-1:0] c_d;
        bit            unc, cor, idle_now, issue, blocked, c_v, c_scrub;
        int            a, c_a, sel;
        a = int'(bus.addr);
        sel = int'(inj_sel);
        unc = 0; cor = 0; bad = '0; v = '0;
        if (m_cap_v) begin
            v = majority(m_cap_w[0], m_cap_w[1], m_cap_w[2]);
            unc = (m_cap_w[0] != m_cap_w[1]) && (m_cap_w[1] != m_cap_w[2]) &&
                  (m_cap_w[0] != m_cap_w[2]);
            for (int k = 0; k < 3; k++) bad[k] = (m_cap_w[k] != v);
            cor = !unc && (bad != 0);
        end
        m_rvalid = m_cap_v && m_cap_u;
        if (m_rvalid) m_rdata = v;
        m_rerr = m_rvalid && unc;

        // the repair to attempt this edge
        c_v = 0; c_scrub = 0; c_a = 0; c_d = '0; c_mask = '0;
        if (cor) begin
            c_v = 1; c_scrub = !m_cap_u; c_a = m_cap_a; c_d = v; c_mask = bad;
        end else if (m_pend_v) begin
            c_v = 1; c_scrub = m_pend_scrub; c_a = m_pend_a; c_d = m_pend_d; c_mask = m_pend_mask;
        end
        blocked = bus.we || inj_en;

        idle_now = !bus.re && !bus.we && !inj_en && !m_pend_v && !m_busy;
        issue    = idle_now && (m_idle == SI - 1);

        m_cap_v = bus.re || issue;
        m_cap_u = bus.re;
        if (bus.re) begin
            m_cap_a = a;
        end else if (issue) begin
            m_cap_a = m_saddr;
        end
        if (m_cap_v) for (int k = 0; k < 3; k++) m_cap_w[k] = m_mem[k][m_cap_a];

        if (bus.we) begin
            for (int k = 0; k < 3; k++) m_mem[k][a] = bus.wdata;
        end else if (inj_en) begin
            if (sel < 3) m_mem[sel][a] = m_mem[sel][a] ^ inj_mask;
        end else if (c_v) begin
            for (int k = 0; k < 3; k++) if (c_mask[k]) m_mem[k][c_a] = c_d;
        end

        m_pend_v = 0;
        if (c_v && blocked && (a != c_a)) begin
            m_pend_v = 1; m_pend_scrub = c_scrub; m_pend_a = c_a;
            m_pend_d = c_d; m_pend_mask = c_mask;
        end

        if (clr_stats) begin
            m_corr = 0; m_uncorr = 0; m_fmap = '0;
        end else begin
            if (cor && m_corr < CMAX) m_corr++;
            if (unc && m_uncorr < CMAX) m_uncorr++;
            if (cor) m_fmap = m_fmap | bad;
        end

        m_busy = issue || (m_pend_v && m_pend_scrub);
        m_wrap = issue && (m_saddr == DEPTH - 1);
        if (issue) m_saddr = (m_saddr + 1) % DEPTH;
        m_idle = issue ? 0 : (idle_now ? m_idle + 1 : 0);
    endtask

    task automatic compare_all();
        check("rvalid", bus.rvalid, m_rvalid);
        check("rdata", bus.rdata, m_rdata);
        check("rerr", bus.rerr, m_rerr);
        check("corr_cnt", corr_cnt, m_corr);
        check("uncorr_cnt", uncorr_cnt, m_uncorr);
        check("fault_map", fault_map, m_fmap);
        check("scrub_busy", scrub_busy, m_busy);
        check("scrub_wrap", scrub_wrap, m_wrap);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        bus.we = 0; bus.re = 0; inj_en = 0; clr_stats = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (scrub_wrap) n_wrap++;
    endtask

    task automatic op_idle(input int n);
        set_idle();
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic op_write(input int a, input logic [DW-1:0] d);
        set_idle(); bus.we = 1; bus.addr = AW'(a); bus.wdata = d;
        cycle(); set_idle();
    endtask

    task automatic op_read(input int a);
        set_idle(); bus.re = 1; bus.addr = AW'(a);
        cycle(); set_idle();
    endtask

    task automatic op_rw(input int a, input logic [DW-1:0] d);
        set_idle(); bus.re = 1; bus.we = 1; bus.addr = AW'(a); bus.wdata = d;
        cycle(); set_idle();
    endtask

    task automatic op_inj(input int sel, input int a, input logic [DW-1:0] mask);
        set_idle(); inj_en = 1; inj_sel = 2'(sel); bus.addr = AW'(a); inj_mask = mask;
        cycle(); set_idle();
    endtask

    task automatic op_clr();
        set_idle(); clr_stats = 1;
        cycle(); set_idle();
    endtask

    // called just after a checked edge; reset lands between clock edges
    task automatic async_reset(input string tag);
        set_idle();
        #3 rst_n = 0;
        #1;
        model_reset();
        check({tag, "_rvalid0"}, bus.rvalid, 0);
        check({tag, "_busy0"}, scrub_busy, 0);
        check({tag, "_corr0"}, corr_cnt, 0);
        check({tag, "_rdata0"}, bus.rdata, 0);
        compare_all();
        @(posedge clk);
        #1 compare_all();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        bus.addr = '0; bus.wdata = '0;
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < DEPTH; a++) m_mem[k][a] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 compare_all();
        @(negedge clk);
        rst_n = 1;

        for (int a = 0; a < DEPTH; a++) op_write(a, '0);

        // basic write/read and latency
        op_write(1, 8'hA5);
        op_read(1);
        check("lat_not_yet", bus.rvalid, 0);
        op_idle(1);
        check("rd_valid", bus.rvalid, 1);
        check("rd_data", bus.rdata, 8'hA5);
        check("rd_noerr", bus.rerr, 0);
        check("rd_corr0", corr_cnt, 0);

        // single-replica fault corrected and repaired
        op_inj(1, 1, 8'h0F);
        op_read(1); op_idle(1);
        check("corr_data", bus.rdata, 8'hA5);
        check("corr_cnt1", corr_cnt, 1);
        check("corr_fmap", fault_map, 3'b010);
        op_read(1); op_idle(1);
        check("repaired", corr_cnt, 1);

        // uncorrectable word, no repair
        op_inj(0, 2, 8'h01);
        op_inj(1, 2, 8'h02);
        op_read(2); op_idle(1);
        check("unc_rerr", bus.rerr, 1);
        check("unc_cnt", uncorr_cnt, 1);
        check("unc_data", bus.rdata, 8'h00);
        op_read(2); op_idle(1);
        check("unc_again", uncorr_cnt, 2);

        // repair deferred by a write elsewhere
        op_inj(2, 3, 8'hFF);
        op_read(3);
        op_write(4, 8'h55);
        op_idle(1);
        op_read(3); op_idle(1);
        check("defer_data", bus.rdata, 8'h00);
        check("defer_corr", corr_cnt, 2);

        // repair cancelled by a write to the same address
        op_inj(2, 5, 8'hF0);
        op_read(5);
        op_write(5, 8'h77);
        op_read(5); op_idle(1);
        check("cancel_data", bus.rdata, 8'h77);
        check("cancel_corr", corr_cnt, 3);

        // simultaneous read and write returns old data
        op_rw(1, 8'h3C); op_idle(1);
        check("rbw_old", bus.rdata, 8'hA5);
        op_read(1); op_idle(1);
        check("rbw_new", bus.rdata, 8'h3C);

        // background scrubber finds and fixes a fault on its own
        begin
            int w0;
            w0 = n_wrap;
            op_inj(0, 7, 8'h3C);
            op_idle(100);
            check("scrub_corr", corr_cnt, 4);
            check("scrub_fmap", fault_map, 3'b111);
            check("scrub_wrapped", 32'(n_wrap - w0), 1);
            op_read(7); op_idle(1);
            check("scrub_data", bus.rdata, 8'h00);
            check("scrub_stable", corr_cnt, 4);
        end

        // clear coinciding with an increment: clear wins
        op_inj(1, 6, 8'h01);
        op_read(6);
        op_clr();
        check("clr_corr", corr_cnt, 0);
        check("clr_unc", uncorr_cnt, 0);
        check("clr_fmap", fault_map, 0);

        // reset while a scrub is in flight
        for (int i = 0; i < 20 && !m_busy; i++) op_idle(1);
        check("busy_before_rst", scrub_busy, 1);
        async_reset("rst_scrub");

        // reset with a pending repair: it must not be written after release
        op_inj(1, 8, 8'h81);
        op_read(8);
        op_write(9, 8'h12);
        async_reset("rst_pend");
        op_idle(1);
        op_read(8); op_idle(1);
        check("no_stray_corr", corr_cnt, 1);
        check("no_stray_fmap", fault_map, 3'b010);
        check("no_stray_data", bus.rdata, 8'h00);

        // randomized traffic with periodic idle windows for the scrubber
        for (int i = 0; i < 1500; i++) begin
            if ((i % 150) >= 120) begin
                set_idle();
            end else begin
                bus.we    = ($urandom_range(0, 99) < 12);
                bus.re    = ($urandom_range(0, 99) < 30);
                inj_en    = ($urandom_range(0, 99) < 10);
                clr_stats = ($urandom_range(0, 99) < 2);
                bus.addr  = AW'($urandom_range(0, DEPTH - 1));
                bus.wdata = DW'($urandom);
                inj_sel   = 2'($urandom_range(0, 3));
                inj_mask  = DW'($urandom);
            end
            cycle();
        end
        set_idle();
        for (int a = 0; a < DEPTH; a++) op_read(a);
        op_idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tmr_scrub_mem.md
Name: tmr_scrub_mem

Overview:
Parametrised successor to the team's triplicated single-port memory.
- Keeps majority-voted synchronous reads and scrub-on-read repair.
- Adds a background scrubber that walks the whole array when the port is idle.
- Adds deferred repair when a user write blocks a correction, and detection of uncorrectable words.
- Adds saturating correction/uncorrectable counters, a sticky per-replica fault map, and a fault-injection port for verification.
- Sits between a processor-side SRAM client and three inferred RAM replicas.

Parameters:
ADDR_W, 8, address width; depth = 2^ADDR_W
DATA_W, 8, word width
SCRUB_EN, 1, 1 enables the background scrubber; 0 removes it
SCRUB_INTERVAL, 16, idle cycles required before each background scrub read (>=1)
CNT_W, 16, width of the error counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
we  in  1  write enable; writes wdata to all three replicas at addr
addr  in  ADDR_W  user address
wdata  in  DATA_W  write data
re  in  1  user read enable
rdata  out  DATA_W  voted read data
rvalid  out  1  one-cycle pulse: rdata is valid for a user read
rerr  out  1  pulses with rvalid when the word was uncorrectable
inj_en  in  1  fault injection strobe
inj_sel  in  2  replica to corrupt (0..2; 3 = no-op)
inj_mask  in  DATA_W  XOR mask applied to replica inj_sel at addr
clr_stats  in  1  synchronous clear of counters and fault_map
corr_cnt  out  CNT_W  number of corrected words, saturating
uncorr_cnt  out  CNT_W  number of uncorrectable words, saturating
fault_map  out  3  sticky: bit k set when replica k was ever repaired
scrub_busy  out  1  a scrub read or repair is in flight
scrub_wrap  out  1  one-cycle pulse when the scrub address wraps to 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs, counters, pipeline registers, scrub address, idle counter and pending repair go to 0; FSM goes to IDLE.
  - Memory contents are not reset; simulation-only zero init is allowed.
- Read pipeline:
  - re sampled at edge T captures the three replicas at addr into q0/q1/q2 plus a tag (user or scrub).
  - voted = bitwise majority of q0/q1/q2.
  - At edge T+1: rdata <= voted and rvalid <= 1 for a user tag. Latency is 1 cycle from the re edge.
  - rdata holds its value between reads.
- Classification of a captured word:
  - Uncorrectable: all three words pairwise differ. rerr pulses (user tag only); uncorr_cnt increments; no repair.
  - Correctable: any replica differs from voted. corr_cnt increments; the fault_map bit of each differing replica is set; the differing replicas are rewritten with voted.
- Write priority per edge: we > inj_en > repair. Injection XORs the mask into one replica only.
- Repair timing:
  - The repair is performed at edge T+1 if neither we nor inj_en is active.
  - Otherwise it is held in a one-entry pending register (addr, voted, replica mask) and retried each following cycle.
  - A user write or injection to the pending address cancels the pending repair; counters are unaffected.
  - A new correction arriving while one is pending: the pending repair is lost (counted, not written).
- Read-during-repair: a read at edge T+1 to the repaired address returns pre-repair memory contents (read-before-write). The voted value is still correct and the error is counted again.
- Scrubber FSM (SCRUB_EN=1), states IDLE, WAIT, RD, CHK:
  - The idle counter increments each cycle with re=0, we=0, inj_en=0 and no pending repair; it resets to 0 otherwise.
  - At SCRUB_INTERVAL the FSM issues an internal read at scrub_addr.
  - A user re/we in that same cycle wins: the scrub is not issued and the counter restarts.
  - After each issued scrub read, scrub_addr increments, wrapping 2^ADDR_W-1 -> 0 with a scrub_wrap pulse.
  - Scrub results never assert rvalid or rerr but do update counters, fault_map and repairs.
  - scrub_busy is high from scrub issue until its repair completes or is dropped.
- Counters saturate at all-ones. clr_stats zeroes the counters and fault_map; if an increment coincides with clr_stats, clear wins.
- Simultaneous re and we to the same address: read returns old data (read-before-write).

Test Plan:
- Write 0xA5 @0x10, read @0x10 -> rvalid one cycle after re, rdata=0xA5, rerr=0, corr_cnt=0.
- inj_sel=1 mask=0x0F @0x10, read -> rdata=0xA5, corr_cnt=1, fault_map=3'b010; second read -> corr_cnt stays 1.
- Inject replica 0 mask 0x01 and replica 1 mask 0x02 @0x20 (data 0x00), read -> rerr=1, uncorr_cnt=1, rdata=0x00 (majority is bitwise), no repair.
- Inject replica 2 @0x30, read, then drive we @0x40 next cycle -> repair deferred one cycle, later read @0x30 leaves corr_cnt=1; repeat with we @0x30 -> repair cancelled, data=new wdata.
- SCRUB_INTERVAL=4, ADDR_W=4, inject replica 0 @0x7, idle -> scrubber corrects it without any user read, corr_cnt=1, scrub_wrap after 16 scrub reads.
- Assert rst_n low mid-scrub with a pending repair -> all outputs 0 immediately; after release no stray repair write; clr_stats with an increment in the same cycle -> counters 0.
